// File: rtl/multi_issue_decode.sv
// multi_issue_decode: ISSUE_W-wide decode stage between fetch and execute.
// Holds the architectural register file (written by NWB writeback buses),
// splits a bundle across cycles on an intra-bundle RAW dependency and
// discards in-flight work on a taken branch.
// Optional feature macro: FWD_BYPASS_EN (same-cycle writeback forwarding
// into operand reads). Without it a writeback is visible one cycle later.
module multi_issue_decode #(
    parameter int ISSUE_W = 2,
    parameter int DATA_W  = 16,
    parameter int NREG    = 16,
    parameter int NWB     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      is_branch_taken,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ISSUE_W*16-1:0]     instr,
    input  logic [15:0]               pc,
    input  logic [NWB-1:0]            wb_en,
    input  logic [NWB*4-1:0]          wb_idx,
    input  logic [NWB*DATA_W-1:0]     wb_val,
    output logic [ISSUE_W-1:0]        out_valid,
    output logic [ISSUE_W*4-1:0]      opcode,
    output logic [ISSUE_W*4-1:0]      rd,
    output logic [ISSUE_W*DATA_W-1:0] op1,
    output logic [ISSUE_W*DATA_W-1:0] op2,
    output logic [ISSUE_W*5-1:0]      imm,
    output logic [ISSUE_W-1:0]        imm_flag,
    output logic [ISSUE_W*16-1:0]     branch_target,
    output logic [ISSUE_W*16-1:0]     instrout
);

    localparam int RIDX_W = 4;

    typedef enum logic [0:0] {ST_PASS = 1'b0, ST_SPLIT = 1'b1} state_t;

    state_t              state_r, state_next_s;
    logic [DATA_W-1:0]   regs_r     [NREG];
    logic [DATA_W-1:0]   rf_view_s  [NREG];
    logic [15:0]         buf_instr_r [ISSUE_W];
    logic [15:0]         buf_pc_r;
    logic [ISSUE_W-1:0]  buf_live_r;
    logic [15:0]         src_instr_s [ISSUE_W];
    logic [15:0]         src_pc_s;
    logic [ISSUE_W-1:0]  src_live_s;
    logic [ISSUE_W-1:0]  dep_s;
    logic [ISSUE_W-1:0]  issue_mask_s;
    logic [ISSUE_W-1:0]  remain_mask_s;
    logic                blocked_s;
    logic                split_s;
    logic                ready_s;
    logic                issue_go_s;
    logic [ISSUE_W-1:0]  lane_imm_form_s;
    logic [DATA_W-1:0]   lane_op1_s [ISSUE_W];
    logic [DATA_W-1:0]   lane_op2_s [ISSUE_W];
    logic [4:0]          lane_imm_s [ISSUE_W];
    logic [15:0]         lane_bt_s  [ISSUE_W];

    // A slot produces a register result unless it is a branch or targets R0.
    function automatic logic slot_writes(input logic [3:0] op, input logic [3:0] dst);
        return (op != 4'hF) && (dst != 4'h0);
    endfunction

    // Immediate form is signalled by the top two opcode bits.
    function automatic logic is_imm_form(input logic [1:0] op_hi);
        return op_hi == 2'b10;
    endfunction

    // Register fields a slot is considered to read for hazard purposes.
    function automatic logic reads_reg(input logic imm_form, input logic [3:0] dst,
                                       input logic [3:0] src1, input logic [3:0] src2,
                                       input logic [3:0] r);
        return (src1 == r) || (src2 == r) || (imm_form && (dst == r));
    endfunction

    // Register file: writebacks land every edge; a later bus overrides an earlier one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) regs_r[r] <= '0;
        end else begin
            for (int j = 0; j < NWB; j++) begin
                if (wb_en[j] && (wb_idx[RIDX_W*j +: RIDX_W] != 4'h0)) begin
                    regs_r[wb_idx[RIDX_W*j +: RIDX_W]] <= wb_val[DATA_W*j +: DATA_W];
                end
            end
        end
    end

    // Read view of the register file, optionally forwarding this cycle's writebacks.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            rf_view_s[r] = regs_r[r];
`ifdef FWD_BYPASS_EN
            for (int j = 0; j < NWB; j++) begin
                rf_view_s[r] = (wb_en[j] && (wb_idx[RIDX_W*j +: RIDX_W] == RIDX_W'(r)))
                               ? wb_val[DATA_W*j +: DATA_W] : rf_view_s[r];
            end
`endif
        end
        rf_view_s[0] = '0;
    end

    // Bundle under decode: buffered remainder while splitting, else the fetch bundle.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) src_instr_s[k] = instr[16*k +: 16];
        src_pc_s   = pc;
        src_live_s = {ISSUE_W{1'b1}};
        if (state_r == ST_SPLIT) begin
            for (int k = 0; k < ISSUE_W; k++) src_instr_s[k] = buf_instr_r[k];
            src_pc_s   = buf_pc_r;
            src_live_s = buf_live_r;
        end else begin
            src_pc_s   = pc;
            src_live_s = {ISSUE_W{1'b1}};
        end
    end

    // RAW check: everything from the lowest dependent live slot upward is deferred.
    always_comb begin
        dep_s        = '0;
        issue_mask_s = '0;
        blocked_s    = 1'b0;
        for (int d = 0; d < ISSUE_W; d++) begin
            for (int i = 0; i < d; i++) begin
                dep_s[d] = dep_s[d] |
                    (src_live_s[i] &
                     slot_writes(src_instr_s[i][15:12], src_instr_s[i][11:8]) &
                     reads_reg(is_imm_form(src_instr_s[d][15:14]), src_instr_s[d][11:8],
                               src_instr_s[d][7:4], src_instr_s[d][3:0],
                               src_instr_s[i][11:8]));
            end
            blocked_s       = blocked_s | (src_live_s[d] & dep_s[d]);
            issue_mask_s[d] = src_live_s[d] & ~blocked_s;
        end
        remain_mask_s = src_live_s & ~issue_mask_s;
        split_s       = |remain_mask_s;
    end

    // Per-lane decode of the selected bundle, operands read from the current view.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            lane_imm_form_s[k] = is_imm_form(src_instr_s[k][15:14]);
            if (lane_imm_form_s[k]) begin
                lane_imm_s[k] = src_instr_s[k][4:0];
                lane_op1_s[k] = rf_view_s[src_instr_s[k][11:8]];
                lane_op2_s[k] = {{(DATA_W-5){src_instr_s[k][4]}}, src_instr_s[k][4:0]};
            end else begin
                lane_imm_s[k] = 5'b0;
                lane_op1_s[k] = rf_view_s[src_instr_s[k][7:4]];
                lane_op2_s[k] = rf_view_s[src_instr_s[k][3:0]];
            end
            if (src_instr_s[k][15:12] == 4'hF) begin
                lane_bt_s[k] = src_pc_s + 16'(k) +
                               {{4{src_instr_s[k][11]}}, src_instr_s[k][11:0]};
            end else begin
                lane_bt_s[k] = 16'h0000;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_PASS;
        else        state_r <= state_next_s;
    end

    // FSM next state: flush returns to PASS; a deferred remainder keeps us in SPLIT.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_PASS: begin
                if (is_branch_taken)          state_next_s = ST_PASS;
                else if (issue_go_s && split_s) state_next_s = ST_SPLIT;
                else                          state_next_s = ST_PASS;
            end
            ST_SPLIT: begin
                if (is_branch_taken) state_next_s = ST_PASS;
                else if (stall)      state_next_s = ST_SPLIT;
                else if (split_s)    state_next_s = ST_SPLIT;
                else                 state_next_s = ST_PASS;
            end
            default: state_next_s = ST_PASS;
        endcase
    end

    // FSM outputs: acceptance handshake and issue strobe.
    always_comb begin
        ready_s    = 1'b0;
        issue_go_s = 1'b0;
        case (state_r)
            ST_PASS: begin
                ready_s    = !stall && !is_branch_taken;
                issue_go_s = ready_s && in_valid;
            end
            ST_SPLIT: begin
                ready_s    = 1'b0;
                issue_go_s = !stall && !is_branch_taken;
            end
            default: begin
                ready_s    = 1'b0;
                issue_go_s = 1'b0;
            end
        endcase
        in_ready = ready_s & reset;
    end

    // Remainder buffer: captured on a split, cleared on flush or a clean issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ISSUE_W; k++) buf_instr_r[k] <= 16'h0000;
            buf_pc_r   <= 16'h0000;
            buf_live_r <= '0;
        end else if (is_branch_taken) begin
            buf_live_r <= '0;
        end else if (issue_go_s) begin
            for (int k = 0; k < ISSUE_W; k++) buf_instr_r[k] <= src_instr_s[k];
            buf_pc_r   <= src_pc_s;
            buf_live_r <= remain_mask_s;
        end
    end

    // Registered lane outputs: load on issue, hold on stall, drop valid otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid     <= '0;
            opcode        <= '0;
            rd            <= '0;
            op1           <= '0;
            op2           <= '0;
            imm           <= '0;
            imm_flag      <= '0;
            branch_target <= '0;
            instrout      <= '0;
        end else if (is_branch_taken) begin
            out_valid <= '0;
        end else if (stall) begin
            out_valid <= out_valid;
        end else if (issue_go_s) begin
            out_valid <= issue_mask_s;
            for (int k = 0; k < ISSUE_W; k++) begin
                opcode[4*k +: 4]             <= src_instr_s[k][15:12];
                rd[4*k +: 4]                 <= src_instr_s[k][11:8];
                op1[DATA_W*k +: DATA_W]      <= lane_op1_s[k];
                op2[DATA_W*k +: DATA_W]      <= lane_op2_s[k];
                imm[5*k +: 5]                <= lane_imm_s[k];
                imm_flag[k]                  <= lane_imm_form_s[k];
                branch_target[16*k +: 16]    <= lane_bt_s[k];
                instrout[16*k +: 16]         <= src_instr_s[k];
            end
        end else begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_multi_issue_decode.sv
// Self-checking bench for multi_issue_decode (ISSUE_W=2, NWB=2).
// Directed scenarios followed by randomized traffic, all compared against
// a slot-list reference model of the decode stage.
module tb_multi_issue_decode;

    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, stall, is_branch_taken, in_valid, in_ready;
    logic [IW*16-1:0] instr;
    logic [15:0]     pc;
    logic [1:0]      wb_en;
    logic [7:0]      wb_idx;
    logic [31:0]     wb_val;
    logic [IW-1:0]   out_valid, imm_flag;
    logic [IW*4-1:0] opcode, rd;
    logic [IW*16-1:0] op1, op2, branch_target, instrout;
    logic [IW*5-1:0] imm;

    multi_issue_decode dut (
        .clk(clk), .reset(reset), .stall(stall), .is_branch_taken(is_branch_taken),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc(pc),
        .wb_en(wb_en), .wb_idx(wb_idx), .wb_val(wb_val), .out_valid(out_valid),
        .opcode(opcode), .rd(rd), .op1(op1), .op2(op2), .imm(imm), .imm_flag(imm_flag),
        .branch_target(branch_target), .instrout(instrout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_regs [16];
    int          pend_q[$];
    logic [15:0] pend_bundle [IW];
    logic [15:0] pend_pc;
    logic [IW-1:0] e_valid;
    logic [3:0]  e_opc [IW];
    logic [3:0]  e_rd  [IW];
    logic [15:0] e_op1 [IW];
    logic [15:0] e_op2 [IW];
    logic [15:0] e_bt  [IW];
    logic [15:0] e_ins [IW];
    logic        e_iflag [IW];
    logic [4:0]  e_imm [IW];

    function automatic logic [15:0] m_read(input logic [3:0] r);
        logic [15:0] v;
        if (r == 4'd0) return 16'h0000;
        v = m_regs[r];
`ifdef FWD_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (wb_en[j] && wb_idx[4*j +: 4] == r) v = wb_val[16*j +: 16];
`endif
        return v;
    endfunction

    function automatic logic m_ready();
        return reset && (pend_q.size() == 0) && !stall && !is_branch_taken;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_regs[r] = 16'h0000;
        pend_q.delete();
        e_valid = '0;
    endtask

    // One clock edge of behaviour: decode the current slot list, then commit writebacks.
    task automatic model_step();
        int          slots[$];
        logic [15:0] b [IW];
        logic [15:0] bpc;
        logic [15:0] written;
        logic        stop;
        if (is_branch_taken) begin
            e_valid = '0;
            pend_q.delete();
        end else if (!stall) begin
            if (pend_q.size() > 0) begin
                slots = pend_q; b = pend_bundle; bpc = pend_pc;
            end else if (in_valid) begin
                for (int s = 0; s < IW; s++) begin
                    slots.push_back(s);
                    b[s] = instr[16*s +: 16];
                end
                bpc = pc;
            end
            e_valid = '0;
            pend_q.delete();
            written = 16'h0000;
            stop = 1'b0;
            foreach (slots[n]) begin
                int s;
                logic [15:0] ins;
                logic is_imm;
                s = slots[n];
                ins = b[s];
                is_imm = (ins[15:14] == 2'b10);
                if (written[ins[7:4]] || written[ins[3:0]] || (is_imm && written[ins[11:8]]))
                    stop = 1'b1;
                if (stop) begin
                    pend_q.push_back(s);
                end else begin
                    e_valid[s] = 1'b1;
                    e_opc[s] = ins[15:12];
                    e_rd[s]  = ins[11:8];
                    e_ins[s] = ins;
                    e_iflag[s] = is_imm;
                    e_imm[s] = ins[4:0];
                    e_op1[s] = is_imm ? m_read(ins[11:8]) : m_read(ins[7:4]);
                    e_op2[s] = is_imm ? {{11{ins[4]}}, ins[4:0]} : m_read(ins[3:0]);
                    e_bt[s]  = (ins[15:12] == 4'hF) ? (bpc + 16'(s) + {{4{ins[11]}}, ins[11:0]}) : 16'h0000;
                    if (ins[15:12] != 4'hF && ins[11:8] != 4'd0) written[ins[11:8]] = 1'b1;
                end
            end
            if (pend_q.size() > 0) begin
                pend_bundle = b;
                pend_pc = bpc;
            end
        end
        for (int j = 0; j < 2; j++)
            if (wb_en[j] && wb_idx[4*j +: 4] != 4'd0) m_regs[wb_idx[4*j +: 4]] = wb_val[16*j +: 16];
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", out_valid, e_valid);
        for (int k = 0; k < IW; k++) begin
            if (e_valid[k]) begin
                check_eq($sformatf("opcode[%0d]", k), opcode[4*k +: 4], e_opc[k]);
                check_eq($sformatf("rd[%0d]", k), rd[4*k +: 4], e_rd[k]);
                check_eq($sformatf("op1[%0d]", k), op1[16*k +: 16], e_op1[k]);
                check_eq($sformatf("op2[%0d]", k), op2[16*k +: 16], e_op2[k]);
                check_eq($sformatf("imm_flag[%0d]", k), imm_flag[k], e_iflag[k]);
                check_eq($sformatf("branch_target[%0d]", k), branch_target[16*k +: 16], e_bt[k]);
                check_eq($sformatf("instrout[%0d]", k), instrout[16*k +: 16], e_ins[k]);
                if (e_iflag[k]) check_eq($sformatf("imm[%0d]", k), imm[5*k +: 5], e_imm[k]);
            end
        end
    endtask

    // Inputs are set just after a rising edge; check ready, advance, check outputs.
    task automatic step();
        #1;
        check_eq("in_ready", in_ready, m_ready());
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1'b0);
        check_eq({tag, "_out_valid"}, out_valid, '0);
        check_eq({tag, "_opcode"}, opcode, '0);
        check_eq({tag, "_rd"}, rd, '0);
        check_eq({tag, "_op1"}, op1, '0);
        check_eq({tag, "_op2"}, op2, '0);
        check_eq({tag, "_imm"}, imm, '0);
        check_eq({tag, "_imm_flag"}, imm_flag, '0);
        check_eq({tag, "_branch_target"}, branch_target, '0);
        check_eq({tag, "_instrout"}, instrout, '0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 5)),
               4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
        if ($urandom_range(0, 3) == 0) ins[11:0] = 12'($urandom);
        return ins;
    endfunction

    initial begin
        reset = 1'b0; stall = 1'b0; is_branch_taken = 1'b0; in_valid = 1'b0;
        instr = '0; pc = 16'h0000; wb_en = 2'b00; wb_idx = 8'h00; wb_val = 32'h0;
        model_reset();

        // Reset state and release
        #12;
        check_reset_outputs("rst0");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();

        // Independent bundle after preloading R1/R2
        wb_en = 2'b11; wb_idx = {4'd2, 4'd1}; wb_val = {16'h5678, 16'h1234};
        step();
        wb_en = 2'b00; instr = {16'h4412, 16'h3312}; pc = 16'h0100; in_valid = 1'b1;
        step();
        check_eq("t2_valid", out_valid, 2'b11);
        check_eq("t2_op1_l0", op1[15:0], 16'h1234);
        check_eq("t2_op2_l0", op2[15:0], 16'h5678);
        check_eq("t2_rd_l0", rd[3:0], 4'd3);
        check_eq("t2_rd_l1", rd[7:4], 4'd4);

        // RAW split
        instr = {16'h4534, 16'h3312};
        step();
        check_eq("t3_valid_c1", out_valid, 2'b01);
        in_valid = 1'b0;
        step();
        check_eq("t3_valid_c2", out_valid, 2'b10);
        check_eq("t3_opcode_l1", opcode[7:4], 4'd4);
        check_eq("t3_rd_l1", rd[7:4], 4'd5);
        check_eq("t3_ready_c3", in_ready, 1'b1);

        // Immediate and branch
        wb_en = 2'b01; wb_idx = {4'd0, 4'hA}; wb_val = {16'h0000, 16'h0007};
        step();
        wb_en = 2'b00; instr = {16'hF010, 16'h8A1F}; pc = 16'h0040; in_valid = 1'b1;
        step();
        check_eq("t4_imm_flag_l0", imm_flag[0], 1'b1);
        check_eq("t4_imm_l0", imm[4:0], 5'h1F);
        check_eq("t4_op1_l0", op1[15:0], 16'h0007);
        check_eq("t4_op2_l0", op2[15:0], 16'hFFFF);
        check_eq("t4_bt_l1", branch_target[31:16], 16'h0051);

        // Stall holds outputs even while a writeback changes a source register
        instr = {16'h5113, 16'h6212};
        step();
        stall = 1'b1;
        wb_en = 2'b01; wb_idx = {4'd0, 4'd1}; wb_val = {16'h0000, 16'hABCD};
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("t5_stall_valid", out_valid, 2'b11);
            check_eq("t5_stall_op1_l0", op1[15:0], 16'h1234);
        end
        stall = 1'b0; wb_en = 2'b00; in_valid = 1'b0;
        step();

        // Flush during SPLIT discards the remainder
        instr = {16'h4534, 16'h3312}; in_valid = 1'b1;
        step();
        in_valid = 1'b0; is_branch_taken = 1'b1;
        step();
        check_eq("t5_flush_valid", out_valid, 2'b00);
        is_branch_taken = 1'b0;
        step();
        check_eq("t5_after_flush_valid", out_valid, 2'b00);
        step();

        // Same-cycle writeback vs. operand read, then dual-bus priority
        wb_en = 2'b01; wb_idx = {4'd0, 4'd5}; wb_val = {16'h0000, 16'hBEEF};
        instr = {16'h0000, 16'h1650}; in_valid = 1'b1;
        step();
`ifdef FWD_BYPASS_EN
        check_eq("t6_bypass_op1", op1[15:0], 16'hBEEF);
`else
        check_eq("t6_bypass_op1", op1[15:0], 16'h0000);
`endif
        in_valid = 1'b0; wb_en = 2'b11; wb_idx = {4'd5, 4'd5}; wb_val = {16'h2222, 16'h1111};
        step();
        wb_en = 2'b00; in_valid = 1'b1;
        step();
        check_eq("t6_dual_bus_op1", op1[15:0], 16'h2222);

        // Reset asserted mid-split drops the remainder
        instr = {16'h4534, 16'h3312};
        step();
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #2;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        check_eq("rst_mid_no_remainder", out_valid, 2'b00);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            stall           = ($urandom_range(0, 4) == 0);
            is_branch_taken = ($urandom_range(0, 9) == 0);
            in_valid        = ($urandom_range(0, 3) != 0);
            instr           = {rand_instr(), rand_instr()};
            pc              = 16'($urandom);
            wb_en           = 2'($urandom_range(0, 3));
            wb_idx          = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            wb_val          = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_issue_decode.md
Name: multi_issue_decode

Overview:
Parametrised N-wide successor to the single-slot decode unit. It sits between fetch and execute and decodes a bundle of ISSUE_W 16-bit instructions per cycle. It reads operands from an internal architectural register file that is written by NWB writeback buses. It detects intra-bundle RAW hazards and splits the bundle across cycles, and it flushes on a taken branch.

Parameters:
ISSUE_W, 2, instructions per bundle (1..4)
DATA_W, 16, register and instruction width
NREG, 16, architectural registers (index width RIDX_W = 4)
NWB, 2, writeback buses

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall  in  1  downstream stall; hold outputs
is_branch_taken  in  1  synchronous flush from execute
in_valid  in  1  bundle present
in_ready  out  1  bundle accepted when in_valid && in_ready
instr  in  ISSUE_W*16  slot k = instr[16k+15:16k]
pc  in  16  PC of slot 0; slot k PC = pc+k
wb_en  in  NWB  writeback enables
wb_idx  in  NWB*4  writeback register indices
wb_val  in  NWB*16  writeback data
out_valid  out  ISSUE_W  per-lane valid
opcode  out  ISSUE_W*4  per-lane opcode
rd  out  ISSUE_W*4  per-lane destination register
op1  out  ISSUE_W*16  per-lane operand 1
op2  out  ISSUE_W*16  per-lane operand 2
imm  out  ISSUE_W*5  per-lane raw immediate
imm_flag  out  ISSUE_W  per-lane immediate-form flag
branch_target  out  ISSUE_W*16  per-lane branch target
instrout  out  ISSUE_W*16  per-lane registered instruction

Behaviour:
- Format: opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0].
- Immediate form, opcode[3:2]==2'b10: imm_flag=1, imm=instr[4:0], op1=R[rd], op2=sign-extended imm to 16 bits, bits[7:5] ignored.
- Branch, opcode 4'hF: branch_target = slot PC + sign-extended instr[11:0], mod 2^16. branch_target is 0 for non-branch slots.
- A slot "writes" when opcode != 4'hF and rd != 0.
- R0 always reads as 0; writes to R0 are ignored.
- Register file: NREG x DATA_W flops, all 0 on reset. Writes occur every edge regardless of stall or flush. When multiple buses target the same index in one cycle, the highest-numbered bus wins.
- All outputs are registered, with 1-cycle latency from acceptance.
- Reset: every output is 0, in_ready=0 while reset is asserted, the FSM is in PASS, and the pending buffer is cleared. Reset asserted mid-split drops the remainder.
- FSM states:
  - PASS: in_ready = !stall && !is_branch_taken.
  - SPLIT: in_ready=0.
- Hazard check on a bundle (new or remainder): find the lowest slot d that has rs1, rs2 or (imm form) rd equal to the rd of a writing slot i < d in the same bundle.
  - No such slot: all live slots issue on lanes equal to their slot numbers. Next state is PASS.
  - Such a slot exists: slots below d issue. Slots d..ISSUE_W-1 are buffered and state goes to SPLIT. The next non-stalled cycle re-checks only the buffered slots and issues them on their original lanes.
  - Repeated splits are allowed for ISSUE_W > 2.
- Operands are read at issue time. Deferred slots read the register file in their own issue cycle.
- stall=1: outputs, buffer and state hold. Held op1/op2 are not refreshed by writebacks.
- is_branch_taken=1: on the next edge out_valid=0 and the state goes to PASS. The buffer and any bundle presented that cycle are discarded. Flush has priority over stall and acceptance.
- Cycle with no acceptance and no SPLIT issue: out_valid=0 next edge; other outputs are don't-care but stable.

Optional Feature:
FWD_BYPASS_EN
- Defined: an operand read of register r in a cycle where wb_en[j] && wb_idx[j]==r returns wb_val[j]. Highest j wins; R0 is still 0.
- Undefined: reads return the stored value, so the writeback becomes visible the following cycle.

Test Plan:
1. Reset sequencing: reset=0 at t=0 and again mid-SPLIT -> all outputs 0, in_ready=0; after release, state is PASS and in_ready=1.
2. Independent bundle: preload R1=16'h1234, R2=16'h5678 via wb. Bundle {0x4412, 0x3312} (slot0 rightmost) -> next cycle out_valid=2'b11, lane0 op1=1234 op2=5678 rd=3, lane1 rd=4.
3. RAW split: slot0=0x3312, slot1=0x4534 -> cycle1 out_valid=01, in_ready=0. cycle2 out_valid=10, lane1 opcode=4 rd=5. cycle3 in_ready=1.
4. Immediate and branch: slot0=0x8A1F with R[A]=0x0007 -> imm_flag=1, imm=1F, op1=0007, op2=FFFF. slot1=0xF010, pc=0x0040 -> branch_target lane1 = 0x0051.
5. Stall and flush: stall=1 for 3 cycles -> outputs unchanged. is_branch_taken=1 during SPLIT -> out_valid=00 next edge, remainder never issues.
6. Bypass: wb R5=BEEF in the same cycle as decoding rs1=5 -> op1=BEEF with FWD_BYPASS_EN, 0000 without. Dual-bus write to R5 (bus0=1111, bus1=2222) -> later read gives 2222.
